// File: rtl/crop_yend_apply.sv
// Crops the raster pixel stream to columns X_START..X_END and rows Y_START..yend,
// where yend is sampled from the measurement stage at each frame start.
module crop_yend_apply #(
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned X_START = 160,
    parameter int unsigned X_END   = 479,
    parameter int unsigned Y_START = 120
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    input  logic [15:0] iYEND,
    output logic        oDVAL,
    output logic [9:0]  oDATA,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oSOF,
    output logic        oEOF,
    output logic        oEMPTY,
    output logic [15:0] oCROP_H
);

    localparam logic [15:0] H_LAST = 16'(H_ACT - 1);
    localparam logic [15:0] V_LAST = 16'(V_ACT - 1);
    localparam logic [15:0] V_NUM  = 16'(V_ACT);
    localparam logic [15:0] XS     = 16'(X_START);
    localparam logic [15:0] XE     = 16'(X_END);
    localparam logic [15:0] YS     = 16'(Y_START);
    localparam bit          Y_ZERO = (Y_START == 0);

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_PRE      = 2'd1;
    localparam logic [1:0] ST_CROP     = 2'd2;
    localparam logic [1:0] ST_POST     = 2'd3;

    logic [15:0] x_cnt_r;
    logic [15:0] y_cnt_r;
    logic [15:0] yend_lat_r;
    logic [1:0]  state_r;

    logic        frame_start_s;
    logic        frame_last_s;
    logic [15:0] yend_clamp_s;
    logic [15:0] yend_cur_s;
    logic [1:0]  state_pix_s;
    logic [1:0]  state_nxt_s;
    logic        in_win_s;
    logic        win_last_s;
    logic        empty_s;
    logic [15:0] crop_h_s;

    // Per-pixel decode; the (0,0) pixel already sees the freshly sampled yend.
    always_comb begin
        frame_start_s = (x_cnt_r == 16'd0) && (y_cnt_r == 16'd0);
        frame_last_s  = (x_cnt_r == H_LAST) && (y_cnt_r == V_LAST);
        yend_clamp_s  = (iYEND < V_NUM) ? iYEND : V_LAST;
        yend_cur_s    = frame_start_s ? yend_clamp_s : yend_lat_r;
        if (yend_clamp_s >= YS) begin
            crop_h_s = yend_clamp_s - YS + 16'd1;
        end else begin
            crop_h_s = 16'd0;
        end

        state_pix_s = state_r;
        case (state_r)
            ST_WAIT_SOF, ST_POST: begin
                if (frame_start_s) begin
                    state_pix_s = Y_ZERO ? ST_CROP : ST_PRE;
                end else begin
                    state_pix_s = state_r;
                end
            end
            ST_PRE: begin
                if ((x_cnt_r == 16'd0) && (y_cnt_r == YS)) begin
                    state_pix_s = (yend_cur_s >= YS) ? ST_CROP : ST_POST;
                end else begin
                    state_pix_s = ST_PRE;
                end
            end
            ST_CROP: state_pix_s = ST_CROP;
            default: state_pix_s = ST_WAIT_SOF;
        endcase

        in_win_s   = (state_pix_s == ST_CROP) && (x_cnt_r >= XS) && (x_cnt_r <= XE);
        win_last_s = in_win_s && (x_cnt_r == XE) && (y_cnt_r == yend_cur_s);
        empty_s    = frame_last_s && (yend_cur_s < YS);
        if (win_last_s) begin
            state_nxt_s = ST_POST;
        end else begin
            state_nxt_s = state_pix_s;
        end
    end

    // Raster counters, window state and frame-start yend latch.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_cnt_r    <= 16'd0;
            y_cnt_r    <= 16'd0;
            yend_lat_r <= 16'd0;
            state_r    <= ST_WAIT_SOF;
            oCROP_H    <= 16'd0;
        end else if (iDVAL) begin
            state_r <= state_nxt_s;
            if (frame_start_s) begin
                yend_lat_r <= yend_clamp_s;
                oCROP_H    <= crop_h_s;
            end
            if (x_cnt_r == H_LAST) begin
                x_cnt_r <= 16'd0;
                y_cnt_r <= (y_cnt_r == V_LAST) ? 16'd0 : y_cnt_r + 16'd1;
            end else begin
                x_cnt_r <= x_cnt_r + 16'd1;
            end
        end
    end

    // Registered pixel outputs; everything reads zero outside the window.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL  <= 1'b0;
            oDATA  <= 10'd0;
            oX     <= 16'd0;
            oY     <= 16'd0;
            oSOF   <= 1'b0;
            oEOF   <= 1'b0;
            oEMPTY <= 1'b0;
        end else begin
            oEMPTY <= iDVAL && empty_s;
            if (iDVAL && in_win_s) begin
                oDVAL <= 1'b1;
                oDATA <= iDATA;
                oX    <= x_cnt_r - XS;
                oY    <= y_cnt_r - YS;
                oSOF  <= (x_cnt_r == XS) && (y_cnt_r == YS);
                oEOF  <= win_last_s;
            end else begin
                oDVAL <= 1'b0;
                oDATA <= 10'd0;
                oX    <= 16'd0;
                oY    <= 16'd0;
                oSOF  <= 1'b0;
                oEOF  <= 1'b0;
            end
        end
    end

endmodule
